af_if_ser_driver: RTL and testbench

AF_IF_SER_DRIVER -- requirements
Module: af_if_ser_driver

---
 rtl/af_if_ser_driver.sv | 126 ++++++++++++
 tb/tb_af_if_ser_driver.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/af_if_ser_driver.sv
// af_if_ser_driver: a small input FIFO feeding an MSB-first serialiser.
// Each word becomes one frame of DW SHIFT cycles, preceded by a single
// LOAD cycle that moves the FIFO head into the shift register.
module af_if_ser_driver #(
  parameter DW    = 8,
  parameter DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [DW-1:0]          in_data,
  output logic                   in_ready,
  output logic                   ser_frame,
  output logic                   ser_data,
  output logic                   ser_start,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             ovf_cnt
);

  localparam PW = $clog2(DEPTH);
  localparam LW = PW + 1;
  localparam CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wrPtr_q, rdPtr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      ovf_q, ovf_d;
  logic [DW-1:0]   shReg_q, shReg_d;
  logic [CW-1:0]   bitCnt_q, bitCnt_d;
  logic            push, pop;

  // A word is taken only while there is room; the head leaves during LOAD.
  assign in_ready = (level_q < FULL_LVL);
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == LOAD);

  // Occupancy and overflow counter next-state; overflow saturates at 255.
  always_comb begin
    level_d = level_q;
    ovf_d   = ovf_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (in_valid && !in_ready && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  // FIFO storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= in_data;
    end
  end

  // FIFO pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
      ovf_q   <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Controller next-state: IDLE waits for data, LOAD fetches, SHIFT sends DW bits.
  always_comb begin
    state_d  = state_q;
    shReg_d  = shReg_q;
    bitCnt_d = bitCnt_q;
    case (state_q)
      IDLE: begin
        if (level_q != '0) state_d = LOAD;
      end
      LOAD: begin
        shReg_d  = mem_q[rdPtr_q];
        bitCnt_d = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        shReg_d  = shReg_q << 1;
        bitCnt_d = bitCnt_q + CW'(1);
        if (bitCnt_q == LAST_BIT) begin
          state_d = (level_q != '0) ? LOAD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shReg_q  <= '0;
      bitCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shReg_q  <= shReg_d;
      bitCnt_q <= bitCnt_d;
    end
  end

  assign ser_frame  = (state_q == SHIFT);
  assign ser_start  = (state_q == SHIFT) && (bitCnt_q == '0);
  assign ser_data   = (state_q == SHIFT) & shReg_q[DW-1];
  assign fifo_level = level_q;
  assign ovf_cnt    = ovf_q;

endmodule

// File: tb/tb_af_if_ser_driver.sv
// tb_af_if_ser_driver: directed and randomized checks of the serialiser
// against a timeline model of when each accepted word goes on the wire.
module tb_af_if_ser_driver;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic [DW-1:0]          in_data;
  logic                   in_ready;
  logic                   ser_frame;
  logic                   ser_data;
  logic                   ser_start;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [7:0]             ovf_cnt;

  int checks;
  int errors;

  // Each accepted word is described by its accept cycle and the cycle its
  // frame begins; everything observable follows from those two numbers.
  typedef struct {
    logic [DW-1:0] data;
    int            acc;
    int            start;
  } word_t;

  word_t         wq[$];
  int            cyc;
  int            lastStart;
  int            ovfModel;
  int            capCount;
  logic [DW-1:0] capWord;
  logic [DW-1:0] gotFrames[$];

  af_if_ser_driver #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ser_frame  (ser_frame),
    .ser_data   (ser_data),
    .ser_start  (ser_start),
    .fifo_level (fifo_level),
    .ovf_cnt    (ovf_cnt)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int modelLevel(input int c);
    int n;
    n = 0;
    foreach (wq[i]) if (wq[i].acc <= c && wq[i].start > c) n++;
    return n;
  endfunction

  task automatic modelSerial(input int c, output logic f, output logic d, output logic s);
    f = 1'b0;
    d = 1'b0;
    s = 1'b0;
    foreach (wq[i]) begin
      if (c >= wq[i].start && c < wq[i].start + DW) begin
        f = 1'b1;
        s = (c == wq[i].start);
        d = wq[i].data[DW-1-(c-wq[i].start)];
      end
    end
  endtask

  function automatic logic [DW-1:0] frameAt(input int idx);
    if (idx >= 0 && idx < gotFrames.size()) return gotFrames[idx];
    return 'x;
  endfunction

  task automatic modelReset();
    wq.delete();
    lastStart = -1000;
    ovfModel  = 0;
    capCount  = 0;
  endtask

  // Compare every output against the model for the current cycle and
  // collect finished frames from the wire.
  task automatic checkOutput();
    logic f, d, s;
    int   lvl;
    modelSerial(cyc, f, d, s);
    lvl = modelLevel(cyc);
    check("xz_outputs", 32'($isunknown({ser_data, ser_frame, ser_start})), 32'd0);
    check("ser_frame",  32'(ser_frame),  32'(f));
    check("ser_start",  32'(ser_start),  32'(s));
    check("ser_data",   32'(ser_data),   32'(d));
    check("fifo_level", 32'(fifo_level), 32'(lvl));
    check("in_ready",   32'(in_ready),   32'(lvl < DEPTH));
    check("ovf_cnt",    32'(ovf_cnt),    32'(ovfModel));
    if (ser_frame === 1'b1) begin
      capWord = {capWord[DW-2:0], ser_data};
      capCount++;
      if (capCount == DW) begin
        gotFrames.push_back(capWord);
        capCount = 0;
      end
    end
  endtask

  // Drive one cycle of input, advance the model, then check the next cycle.
  // A word accepted at the next edge starts its frame two cycles later, or
  // one cycle after the previous frame ends if that is later.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d);
    word_t w;
    int    s;
    while (wq.size() > 0 && wq[0].start + DW <= cyc) void'(wq.pop_front());
    in_valid = v;
    in_data  = d;
    if (v) begin
      if (modelLevel(cyc) < DEPTH) begin
        s = cyc + 3;
        if (lastStart + DW + 1 > s) s = lastStart + DW + 1;
        w.data  = d;
        w.acc   = cyc + 1;
        w.start = s;
        wq.push_back(w);
        lastStart = s;
      end else if (ovfModel < 255) begin
        ovfModel++;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    checkOutput();
  endtask

  // Directed scenarios followed by a randomized soak and a mid-frame reset.
  initial begin
    int            found;
    int            nBefore;
    int            pct;
    logic [DW-1:0] rd;

    checks   = 0;
    errors   = 0;
    cyc      = 0;
    capWord  = '0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    modelReset();

    @(negedge clk);
    checkOutput();
    check("reset_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, '0);
    applyStimulus(1'b0, '0);
    rst_n = 1'b1;

    // Single word and its latency.
    applyStimulus(1'b1, 8'hA5);
    applyStimulus(1'b0, '0);
    check("lat_load_cycle", 32'(ser_frame), 32'd0);
    applyStimulus(1'b0, '0);
    check("lat_first_bit", 32'(ser_start), 32'd1);
    repeat (12) applyStimulus(1'b0, '0);
    check("frame_A5", 32'(frameAt(0)), 32'hA5);

    // Back-to-back frames.
    applyStimulus(1'b1, 8'h81);
    applyStimulus(1'b1, 8'h7E);
    repeat (25) applyStimulus(1'b0, '0);
    check("frame_81", 32'(frameAt(1)), 32'h81);
    check("frame_7E", 32'(frameAt(2)), 32'h7E);

    // Overflow while the first frame is being sent.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'h10 + i));
    check("ovf_level_full", 32'(fifo_level), 32'd4);
    check("ovf_ready_low",  32'(in_ready),   32'd0);
    check("ovf_count_2",    32'(ovf_cnt),    32'd2);
    repeat (60) applyStimulus(1'b0, '0);
    for (int i = 0; i < 5; i++) check("ovf_frame_order", 32'(frameAt(3 + i)), 32'(8'h10 + i));

    // Saturation of the overflow counter.
    for (int i = 0; i < 330; i++) begin
      rd = DW'($urandom);
      applyStimulus(1'b1, rd);
    end
    check("ovf_saturated", 32'(ovf_cnt), 32'd255);
    repeat (60) applyStimulus(1'b0, '0);

    // Randomized traffic at several densities.
    for (int i = 0; i < 300; i++) begin
      pct = (i < 100) ? 20 : ((i < 200) ? 60 : 90);
      rd  = DW'($urandom);
      applyStimulus(($urandom_range(0, 99) < pct), rd);
    end
    repeat (60) applyStimulus(1'b0, '0);

    // Reset during the fourth bit of a frame.
    applyStimulus(1'b1, 8'hC3);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      applyStimulus(1'b0, '0);
      if (ser_start === 1'b1) found = 1;
    end
    check("start_seen", 32'(found), 32'd1);
    repeat (3) applyStimulus(1'b0, '0);
    check("pre_reset_in_frame", 32'(ser_frame), 32'd1);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput();
    applyStimulus(1'b0, '0);
    applyStimulus(1'b0, '0);
    rst_n = 1'b1;
    nBefore = gotFrames.size();
    applyStimulus(1'b1, 8'h3C);
    repeat (15) applyStimulus(1'b0, '0);
    check("frames_after_reset", 32'(gotFrames.size() - nBefore), 32'd1);
    check("frame_3C", 32'(frameAt(gotFrames.size() - 1)), 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
